mac_vector_array: RTL

Multi-lane, pipelined multiply-accumulate engine that computes LANES independent dot products of length LEN. Operand pairs stream in through a valid/ready handshake, one element per lane per beat. After LEN accepted beats, the per-lane sums are presented through a valid/ready output handshake. The block sits between the operand buffers and the result writeback path. It adds signed mode, saturation, overflow flags and flow control to the plain single-lane accumulator.

---
 rtl/mac_vector_array.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mac_vector_array.sv
// mac_vector_array: LANES independent dot products of length LEN.
// Operand beats stream in over a valid/ready handshake. Each lane has a
// multiply stage and an accumulate stage. After LEN beats the per-lane sums
// are offered on a valid/ready output handshake. Signed operation,
// saturation and sticky per-lane overflow flags are selected by parameters.

module mac_vector_array #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int LEN        = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH * 3,
    parameter bit SIGNED     = 1'b0,
    parameter bit SAT        = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          Clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   Ain,
    input  logic [LANES*DATA_WIDTH-1:0]   Bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    Cout,
    output logic [LANES-1:0]              ovf,
    output logic [$clog2(LEN+1)-1:0]      beat_cnt
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(LEN + 1);

    // Ones in the low PW bits; its complement is the sign-extension mask.
    localparam logic [ACC_WIDTH-1:0] LOW_ONES  = {ACC_WIDTH{1'b1}} >> (ACC_WIDTH - PW);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX_U = {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX_S = ACC_MAX_U >> 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MIN_S = ~ACC_MAX_S;

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    state_t               state;
    logic                 p_valid;
    logic                 accept;
    logic                 handshake;
    logic [PW-1:0]        prod     [LANES];
    logic [PW-1:0]        mul      [LANES];
    logic [ACC_WIDTH-1:0] acc      [LANES];
    logic [ACC_WIDTH-1:0] acc_next [LANES];
    logic [LANES-1:0]     lane_ovf;

    // Operands are widened to the product width so a plain PW x PW multiply
    // truncated to PW bits gives the exact signed or unsigned product.
    function automatic logic [PW-1:0] widen_op(input logic [DATA_WIDTH-1:0] v);
        return {{DATA_WIDTH{SIGNED && v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] widen_prod(input logic [PW-1:0] p);
        logic [ACC_WIDTH-1:0] r;
        r = ACC_WIDTH'(p);
        if (SIGNED && p[PW-1]) r = r | ~LOW_ONES;
        return r;
    endfunction

    // Returns {overflow, next accumulator value} for one lane.
    function automatic logic [ACC_WIDTH:0] add_lane(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] p);
        logic [ACC_WIDTH:0]   full;
        logic [ACC_WIDTH-1:0] sum;
        logic                 o;
        full = {1'b0, a} + {1'b0, p};
        sum  = full[ACC_WIDTH-1:0];
        o    = 1'b0;
        if (SIGNED) begin
            if ((a[ACC_WIDTH-1] == p[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
                o = 1'b1;
                if (SAT) sum = a[ACC_WIDTH-1] ? ACC_MIN_S : ACC_MAX_S;
            end
        end else if (full[ACC_WIDTH]) begin
            o = 1'b1;
            if (SAT) sum = ACC_MAX_U;
        end
        return {o, sum};
    endfunction

    assign in_ready  = (state == ACCUM) && !Clr;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign handshake = out_valid && out_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_cout
        assign Cout[g*ACC_WIDTH +: ACC_WIDTH] = acc[g];
    end

    // Per-lane product of the incoming beat and next accumulator value.
    always_comb begin
        lane_ovf = '0;
        for (int i = 0; i < LANES; i++) begin
            mul[i] = widen_op(Ain[i*DATA_WIDTH +: DATA_WIDTH]) *
                     widen_op(Bin[i*DATA_WIDTH +: DATA_WIDTH]);
            {lane_ovf[i], acc_next[i]} = add_lane(acc[i], widen_prod(prod[i]));
        end
    end

    // Control FSM: counts accepted beats, drains the last product, holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            beat_cnt <= '0;
        end else if (Clr) begin
            state    <= ACCUM;
            beat_cnt <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (beat_cnt == CW'(LEN - 1)) begin
                            beat_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                DRAIN:   state <= DONE;
                DONE:    if (out_ready) state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

    // Datapath: multiply stage, accumulate stage and sticky overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            ovf     <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else if (Clr) begin
            p_valid <= 1'b0;
            ovf     <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            p_valid <= accept;
            for (int i = 0; i < LANES; i++) begin
                if (accept) prod[i] <= mul[i];
            end
            if (handshake) begin
                p_valid <= 1'b0;
                ovf     <= '0;
                for (int i = 0; i < LANES; i++) acc[i] <= '0;
            end else if (p_valid) begin
                ovf <= ovf | lane_ovf;
                for (int i = 0; i < LANES; i++) acc[i] <= acc_next[i];
            end
        end
    end

endmodule
